// File: rtl/ps2_pkg.sv
// Shared state encoding and constants for the PS/2 scan-code front end.
// Prefix decoding in the top level is enabled by defining PS2_BREAK_DECODE_EN.
package ps2_pkg;
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} ps2_state_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam int         ENTRY_W = 10;
endpackage

// File: rtl/ps2_sync_fifo.sv
// Show-ahead FIFO: head entry is presented combinationally, push and pop may share a cycle,
// a push into a full FIFO without a simultaneous pop is dropped and flagged for one cycle.
module ps2_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                    clk_i,
    input  logic                    srst_n_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [WIDTH-1:0]        wdata_i,
    output logic [WIDTH-1:0]        rdata_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    empty_o,
    output logic                    overflow_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             full;
    logic             pop_ok;
    logic             wr_ok;

    assign full       = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign pop_ok     = pop_i & ~empty_o;
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts the push.
    assign wr_ok      = push_i & (~full | pop_ok);
    assign overflow_o = push_i & full & ~pop_ok;
    assign rdata_o    = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o    = count_q;

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(wr_ok) - (AW+1)'(pop_ok);
        end
    end
endmodule

// File: rtl/ps2_scan_fifo.sv
// PS/2 keyboard receiver: pin sync, KCLK glitch filter, frame FSM with timeout, scan-code FIFO.
// Define PS2_BREAK_DECODE_EN to fold E0/F0 prefixes into the ext/brk bits of the following code.
module ps2_scan_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    KCLK,
    input  logic                    KDAT,
    input  logic                    rd_en,
    output logic [ENTRY_W-1:0]      DATA,
    output logic                    valid,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    frame_err,
    input  logic                    clr_err
);
    localparam int FCW = $clog2(FILT_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FCW-1:0] FILT_MAX = FCW'(FILT_LEN - 1);
    localparam logic [TW-1:0]  TMO_MAX  = TW'(TIMEOUT_CYC - 1);

    logic [SYNC_STAGES-1:0] kclk_sync_q, kdat_sync_q;
    logic                   kclk_filt_q, kclk_filt_dly_q;
    logic [FCW-1:0]         filt_cnt_q;
    logic                   kclk_s, kdat_s, fall;

    ps2_state_e  state_q, state_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_q, parity_d;
    logic [TW-1:0] tmo_q;
    logic        tmo_hit, frame_good, frame_bad;
    logic        push, fifo_ovf, fifo_empty;
    logic [ENTRY_W-1:0] entry;
    logic        overflow_q, frame_err_q;

    assign kclk_s = kclk_sync_q[SYNC_STAGES-1];
    assign kdat_s = kdat_sync_q[SYNC_STAGES-1];
    assign fall   = kclk_filt_dly_q & ~kclk_filt_q;

    // Filtered KCLK only follows the pin after FILT_LEN consecutive disagreeing samples.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            kclk_sync_q     <= '1;
            kdat_sync_q     <= '1;
            kclk_filt_q     <= 1'b1;
            kclk_filt_dly_q <= 1'b1;
            filt_cnt_q      <= '0;
        end else begin
            kclk_sync_q     <= {kclk_sync_q[SYNC_STAGES-2:0], KCLK};
            kdat_sync_q     <= {kdat_sync_q[SYNC_STAGES-2:0], KDAT};
            kclk_filt_dly_q <= kclk_filt_q;
            if (kclk_s == kclk_filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FILT_MAX) begin
                kclk_filt_q <= kclk_s;
                filt_cnt_q  <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + FCW'(1);
            end
        end
    end

    assign tmo_hit = (state_q != S_IDLE) && (tmo_q == TMO_MAX) && !fall;

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        if (tmo_hit) begin
            state_d   = S_IDLE;
            frame_bad = 1'b1;
        end else if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!kdat_s) begin
                        state_d  = S_DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_d  = {kdat_s, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    parity_d = kdat_s;
                    state_d  = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (kdat_s && (^{shift_q, parity_q})) begin
                        frame_good = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_q       <= (fall || state_q == S_IDLE) ? '0 : tmo_q + TW'(1);
            overflow_q  <= (overflow_q & ~clr_err) | fifo_ovf;
            frame_err_q <= (frame_err_q & ~clr_err) | frame_bad;
        end
    end

`ifdef PS2_BREAK_DECODE_EN
    logic ext_q, ext_d, brk_q, brk_d;

    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        push  = 1'b0;
        entry = {ext_q, brk_q, shift_q};
        if (frame_bad) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (frame_good) begin
            if (shift_q == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (shift_q == PS2_BRK) begin
                brk_d = 1'b1;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else begin
            ext_q <= ext_d;
            brk_q <= brk_d;
        end
    end
`else
    assign push  = frame_good;
    assign entry = {2'b00, shift_q};
`endif

    ps2_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (CLK),
        .srst_n_i   (RESET),
        .push_i     (push),
        .pop_i      (rd_en),
        .wdata_i    (entry),
        .rdata_o    (DATA),
        .count_o    (count),
        .empty_o    (fifo_empty),
        .overflow_o (fifo_ovf)
    );

    assign valid     = ~fifo_empty;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_scan_fifo.sv
// Scoreboard bench: frames are driven on the pins, a frame-level model queues expected entries,
// and a monitor pops the FIFO (randomly or on request) and compares the head against the queue.
`timescale 1ns/1ps
module tb_ps2_scan_fifo;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int FILT_LEN    = 3;
    localparam int TIMEOUT_CYC = 300;
    localparam int HALF        = 20;
    localparam int CW          = $clog2(DEPTH) + 1;

    logic CLK = 1'b0, RESET = 1'b0, KCLK = 1'b1, KDAT = 1'b1, rd_en = 1'b0, clr_err = 1'b0;
    logic [9:0]    DATA;
    logic          valid;
    logic [CW-1:0] count;
    logic          overflow, frame_err;

    ps2_scan_fifo #(
        .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .CLK(CLK), .RESET(RESET), .KCLK(KCLK), .KDAT(KDAT), .rd_en(rd_en),
        .DATA(DATA), .valid(valid), .count(count), .overflow(overflow),
        .frame_err(frame_err), .clr_err(clr_err)
    );

    always #5 CLK = ~CLK;

    int         total = 0;
    int         bad   = 0;
    logic [9:0] exp_q[$];
    logic [9:0] mon_e;
    logic       ext_m = 1'b0, brk_m = 1'b0, exp_ovf = 1'b0, exp_ferr = 1'b0;
    logic       reads_on = 1'b0;
    int         cyc = 0;
    int         pop_at = -1;
    int         lat = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Consumer: decides at the negedge whether to pop; the head shown now is what leaves.
    initial begin
        forever begin
            @(negedge CLK);
            if (pop_at == cyc || (reads_on && valid && ($urandom_range(1, 0) == 1))) begin
                rd_en = 1'b1;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got=%0h want=none", DATA);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pop_valid", {31'd0, valid}, 32'd1);
                    check("pop_data", {22'd0, DATA}, {22'd0, mon_e});
                end
            end else begin
                rd_en = 1'b0;
            end
        end
    end

    // Frame-level model: what a good/bad frame does to the queue and flags.
    task automatic model_frame(input logic [7:0] b, input logic good, input logic coinc);
        logic [9:0] ent;
        logic       do_push;
        if (!good) begin
            exp_ferr = 1'b1;
            ext_m    = 1'b0;
            brk_m    = 1'b0;
            return;
        end
        do_push = 1'b1;
        ent     = {2'b00, b};
`ifdef PS2_BREAK_DECODE_EN
        if (b == 8'hE0) begin
            ext_m = 1'b1;
            do_push = 1'b0;
        end else if (b == 8'hF0) begin
            brk_m = 1'b1;
            do_push = 1'b0;
        end else begin
            ent   = {ext_m, brk_m, b};
            ext_m = 1'b0;
            brk_m = 1'b0;
        end
`endif
        if (do_push) begin
            if (exp_q.size() < DEPTH || coinc) exp_q.push_back(ent);
            else exp_ovf = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                              input int nbits, input int glitch_bit, input logic coinc,
                              input logic calib);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge CLK);
            KDAT = fr[i];
            for (int k = 0; k < HALF; k++) begin
                @(negedge CLK);
                if (i == glitch_bit && k == HALF/2) KCLK = 1'b0;
                if (i == glitch_bit && k == HALF/2 + FILT_LEN - 1) KCLK = 1'b1;
            end
            if (i == 10) begin
                model_frame(b, !bad_par && !bad_stop, coinc);
                if (coinc) pop_at = cyc + lat - 1;
            end
            KCLK = 1'b0;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge CLK);
                if (calib && lat == 0 && valid) lat = k;
            end
            KCLK = 1'b1;
        end
        @(negedge CLK);
        KDAT = 1'b1;
    endtask

    task automatic pulse_clr();
        @(negedge CLK);
        clr_err = 1'b1;
        @(negedge CLK);
        clr_err = 1'b0;
        exp_ferr = 1'b0;
        exp_ovf  = 1'b0;
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
        check({tag, "_frame_err"}, {31'd0, frame_err}, {31'd0, exp_ferr});
    endtask

    task automatic drain(input string tag);
        int n;
        reads_on = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || valid) && n < 300) begin
            @(negedge CLK);
            n++;
        end
        reads_on = 1'b0;
        repeat (2) @(negedge CLK);
        check({tag, "_drained"}, {31'd0, valid}, 32'd0);
        check({tag, "_count0"}, {{(32-CW){1'b0}}, count}, 32'd0);
    endtask

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        int         sel;
        logic       bp, bs;

        repeat (5) @(negedge CLK);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_count", {{(32-CW){1'b0}}, count}, 32'd0);
        check("rst_data", {22'd0, DATA}, 32'd0);
        check_flags("rst");
        RESET = 1'b1;
        repeat (5) @(negedge CLK);

        // Basic frame, also measures pin-to-visible latency for the full-FIFO push+pop case.
        send_frame(8'h1C, 1'b0, 1'b0, 11, -1, 1'b0, 1'b1);
        check("calib_seen", {31'd0, (lat != 0)}, 32'd1);
        check("f1c_valid", {31'd0, valid}, 32'd1);
        check("f1c_data", {22'd0, DATA}, 32'h01C);
        check("f1c_count", {{(32-CW){1'b0}}, count}, 32'd1);
        check_flags("f1c");
        drain("f1c");

        send_frame(8'h1C, 1'b1, 1'b0, 11, -1, 1'b0, 1'b0);
        check("badpar_count", {{(32-CW){1'b0}}, count}, 32'd0);
        check_flags("badpar");
        pulse_clr();
        check_flags("clr");

        send_frame(8'hE0, 1'b0, 1'b0, 11, -1, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 11, -1, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0, 11, -1, 1'b0, 1'b0);
        check("pfx_count", {{(32-CW){1'b0}}, count}, exp_q.size());
        if (exp_q.size() != 0) check("pfx_head", {22'd0, DATA}, {22'd0, exp_q[0]});
        drain("pfx");

        for (int i = 0; i <= DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 11, -1, 1'b0, 1'b0);
        check("full_count", {{(32-CW){1'b0}}, count}, DEPTH);
        check_flags("full");
        check("full_head", {22'd0, DATA}, {22'd0, exp_q[0]});
        pulse_clr();
        send_frame(8'h33, 1'b0, 1'b0, 11, -1, 1'b1, 1'b0);
        check("fullpp_count", {{(32-CW){1'b0}}, count}, DEPTH);
        check_flags("fullpp");
        drain("full");

        send_frame(8'h55, 1'b0, 1'b0, 5, -1, 1'b0, 1'b0);
        repeat (TIMEOUT_CYC + 20) @(negedge CLK);
        exp_ferr = 1'b1;
        ext_m = 1'b0;
        brk_m = 1'b0;
        check_flags("tmo");
        pulse_clr();
        send_frame(8'h29, 1'b0, 1'b0, 11, -1, 1'b0, 1'b0);
        check_flags("tmo_next");
        drain("tmo");

        send_frame(8'h5A, 1'b0, 1'b0, 11, 3, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, 11, 9, 1'b0, 1'b0);
        check_flags("glitch");
        drain("glitch");

        reads_on = 1'b1;
        for (int n = 0; n < 16; n++) begin
            sel = $urandom_range(5, 0);
            rb  = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom_range(255, 0));
            bp  = ($urandom_range(7, 0) == 0);
            bs  = ($urandom_range(15, 0) == 0);
            send_frame(rb, bp, bs, 11, -1, 1'b0, 1'b0);
            check("rand_frame_err", {31'd0, frame_err}, {31'd0, exp_ferr});
            if (exp_ferr) pulse_clr();
        end
        drain("rand");

        send_frame(8'h44, 1'b0, 1'b0, 11, -1, 1'b0, 1'b0);
        send_frame(8'h66, 1'b0, 1'b0, 6, -1, 1'b0, 1'b0);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        exp_q.delete();
        ext_m = 1'b0;
        brk_m = 1'b0;
        exp_ovf = 1'b0;
        exp_ferr = 1'b0;
        check("mrst_valid", {31'd0, valid}, 32'd0);
        check("mrst_count", {{(32-CW){1'b0}}, count}, 32'd0);
        check("mrst_data", {22'd0, DATA}, 32'd0);
        check_flags("mrst");
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        send_frame(8'h4B, 1'b0, 1'b0, 11, -1, 1'b0, 1'b0);
        check("post_rst_count", {{(32-CW){1'b0}}, count}, exp_q.size());
        drain("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
